// File: rtl/flipflop_rr_if.sv
// flipflop_rr_if: requester-side request/lock/data and grant bundle for flipflop_rr_ctrl
interface flipflop_rr_if #(parameter int NUM_REQ = 4, parameter int WIDTH = 8);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req, lock, gnt;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic busy;
    logic [IW-1:0] last_owner;
    modport master(output req, lock, wdata, input gnt, busy, last_owner);
    modport slave(input req, lock, wdata, output gnt, busy, last_owner);
endinterface

// File: rtl/flipflop_rr_ctrl.sv
// flipflop_rr_ctrl: round-robin write arbiter for an enable-less register, with locked bursts and clear
module flipflop_rr_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic [WIDTH-1:0] qout,
    output logic [WIDTH-1:0] qin,
    flipflop_rr_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [IW-1:0] owner, owner_n, ptr, ptr_n, last_owner, last_n, nxt_ptr, scan_base, win, idx;
    logic [HW-1:0] hold, hold_n;
    logic [NUM_REQ-1:0] own_oh, scan_req;
    logic win_ok, cont, busy;
    assign busy = state == GRANT;
    assign own_oh = NUM_REQ'(1) << owner;
    assign nxt_ptr = (32'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    assign cont = bus.lock[owner] & bus.req[owner] & (32'(hold) < MAX_HOLD - 1);
    assign bus.busy = busy;
    assign bus.gnt = busy ? own_oh : '0;
    assign bus.last_owner = last_owner;
    // the register has no enable, so it is fed its own output whenever nothing is written
    assign qin = (reset | clr) ? '0 : busy ? bus.wdata[owner*WIDTH +: WIDTH] : qout;
    always_comb begin
        scan_base = busy ? nxt_ptr : ptr;
        scan_req = busy ? bus.req & ~own_oh : bus.req;
        win = '0;
        win_ok = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((32'(scan_base) + 32'(i)) % NUM_REQ);
            if (scan_req[idx]) begin
                win = idx;
                win_ok = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n = ptr;
        hold_n = hold;
        last_n = last_owner;
        if (clr) begin
            state_n = IDLE;
            hold_n = '0;
        end else if (!busy) begin
            state_n = win_ok ? GRANT : IDLE;
            owner_n = win_ok ? win : owner;
        end else begin
            last_n = owner;
            if (cont) begin
                hold_n = hold + 1'b1;
            end else begin
                ptr_n = nxt_ptr;
                hold_n = '0;
                state_n = win_ok ? GRANT : IDLE;
                owner_n = win_ok ? win : owner;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr <= '0;
            hold <= '0;
            last_owner <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr <= ptr_n;
            hold <= hold_n;
            last_owner <= last_n;
        end
    end
endmodule

// File: tb/tb_flipflop_rr_ctrl.sv
// tb_flipflop_rr_ctrl: directed stimulus with a grant/data scoreboard checked by an independent monitor
module tb_flipflop_rr_ctrl;
    logic clk, reset, clr, mon_en;
    logic [7:0] qin, qout;
    int pass_n, tot_n;
    typedef struct {int idx; logic [7:0] d;} exp_t;
    exp_t sb[$];
    flipflop_rr_if #(.NUM_REQ(4), .WIDTH(8)) ifc();
    flipflop_rr_ctrl #(.NUM_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .clr(clr), .qout(qout), .qin(qin), .bus(ifc.slave)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) qout <= qin;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_wd(input int i, input logic [7:0] d);
        ifc.wdata[i*8 +: 8] = d;
    endtask
    initial begin
        bit pv;
        logic [7:0] pd;
        exp_t e;
        pv = 0;
        pd = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (pv) chk("qout_after_write", 32'(qout), 32'(pd));
            pv = 0;
            chk("gnt_onehot0", 32'($onehot0(ifc.gnt)), 32'd1);
            if (!ifc.busy) chk("gnt_zero_when_idle", 32'(ifc.gnt), 32'd0);
            if (ifc.gnt != '0) begin
                if (sb.size() == 0) begin
                    tot_n++;
                    $display("FAIL unexpected_grant: got gnt=%b expected none at %0t", ifc.gnt, $time);
                end else begin
                    e = sb.pop_front();
                    chk("gnt_owner", 32'(ifc.gnt), 32'(1) << e.idx);
                    chk("qin_write", 32'(qin), 32'(e.d));
                    pv = 1;
                    pd = e.d;
                end
            end
        end
    end
    initial begin
        pass_n = 0;
        tot_n = 0;
        mon_en = 0;
        reset = 1;
        clr = 0;
        ifc.req = '0;
        ifc.lock = '0;
        ifc.wdata = '0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_gnt", 32'(ifc.gnt), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_last_owner", 32'(ifc.last_owner), 32'd0);
        chk("rst_qin", 32'(qin), 32'd0);
        step();
        reset = 0;
        mon_en = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_qin_eq_qout", 32'(qin), 32'(qout));
            chk("idle_qout", 32'(qout), 32'h00);
            chk("idle_gnt", 32'(ifc.gnt), 32'd0);
            step();
        end
        // single write from requester 1
        ifc.req = 4'b0010;
        set_wd(1, 8'hA5);
        sb.push_back('{1, 8'hA5});
        step();
        step();
        ifc.req = '0;
        @(negedge clk);
        chk("single_last_owner", 32'(ifc.last_owner), 32'd1);
        step();
        reset = 1;
        step();
        reset = 0;
        // full contention: 0,1,2,3,0
        ifc.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_wd(i, 8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) sb.push_back('{i % 4, 8'h10 + 8'(i % 4)});
        repeat (5) step();
        ifc.req = '0;
        step();
        // locked burst capped at four grants, then requester 0
        ifc.req = 4'b0101;
        ifc.lock = 4'b0100;
        set_wd(2, 8'hC2);
        set_wd(0, 8'hC0);
        for (int i = 0; i < 4; i++) sb.push_back('{2, 8'hC2});
        sb.push_back('{0, 8'hC0});
        repeat (5) step();
        ifc.req = '0;
        ifc.lock = '0;
        step();
        // clear during a grant, held request regranted afterwards
        ifc.req = 4'b1000;
        set_wd(3, 8'h7E);
        sb.push_back('{3, 8'h00});
        sb.push_back('{3, 8'h7E});
        step();
        clr = 1;
        @(negedge clk);
        chk("clr_qin", 32'(qin), 32'd0);
        step();
        clr = 0;
        @(negedge clk);
        chk("clr_gnt", 32'(ifc.gnt), 32'd0);
        chk("clr_qout", 32'(qout), 32'd0);
        chk("clr_last_owner", 32'(ifc.last_owner), 32'd0);
        step();
        ifc.req = '0;
        step();
        @(negedge clk);
        chk("regrant_last_owner", 32'(ifc.last_owner), 32'd3);
        step();
        // reset in the middle of a locked burst
        ifc.req = 4'b0010;
        ifc.lock = 4'b0010;
        set_wd(1, 8'h5A);
        sb.push_back('{1, 8'h5A});
        sb.push_back('{1, 8'h00});
        sb.push_back('{0, 8'h3C});
        sb.push_back('{1, 8'h5A});
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        ifc.req = 4'b0011;
        ifc.lock = '0;
        set_wd(0, 8'h3C);
        @(negedge clk);
        chk("midrst_gnt", 32'(ifc.gnt), 32'd0);
        chk("midrst_busy", 32'(ifc.busy), 32'd0);
        chk("midrst_last_owner", 32'(ifc.last_owner), 32'd0);
        step();
        step();
        ifc.req = '0;
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
